// File: rtl/gumnut_int_ctrl.sv
// rtl/gumnut_int_ctrl.sv - eight-source interrupt controller on the gumnut port bus
//
// Optional feature: define GUMNUT_INT_SYNC_EN to put a two-flop synchronizer
// on every irq_i bit ahead of edge/level sampling (pending sets on the 3rd
// rising edge after an irq_i rise instead of the 1st).
//
// Ports:
//   clk_i       single clock, rising edge
//   rst_i       asynchronous active-low reset
//   irq_i[7:0]  interrupt sources (asynchronous to clk_i)
//   port_adr_i  port address from core
//   port_dat_i  port write data from core
//   port_we_i   port write strobe, one cycle per write
//   port_dat_o  read data, 8'h00 on address miss (OR-able onto core bus)
//   int_req_o   registered interrupt request to core
//   int_ack_i   interrupt acknowledge from core
//
// Registers at BASE_ADDR+0..+3: STATUS (pending, W1C), MASK, CAUSE
// ({valid,4'b0,idx}, write = end-of-interrupt), MODE (1 = edge, 0 = level).

module gumnut_int_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] irq_i,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    input  logic       port_we_i,
    output logic [7:0] port_dat_o,
    output logic       int_req_o,
    input  logic       int_ack_i
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state, state_next;
    logic [7:0] pending, mask, mode, cause, cause_next;
    logic [7:0] src, src_prev, rise, clr, masked;
    logic [7:0] offset;
    logic       hit, wr_status, wr_mask, wr_cause, wr_mode;
    logic [2:0] low_idx;

    // BASE_ADDR <= 8'hFC, so any address below the base wraps to an
    // offset of at least 4 and misses; no separate lower-bound compare.
    assign offset    = port_adr_i - BASE_ADDR;
    assign hit       = (offset[7:2] == 6'd0);
    assign wr_status = port_we_i && hit && (offset[1:0] == 2'd0);
    assign wr_mask   = port_we_i && hit && (offset[1:0] == 2'd1);
    assign wr_cause  = port_we_i && hit && (offset[1:0] == 2'd2);
    assign wr_mode   = port_we_i && hit && (offset[1:0] == 2'd3);

`ifdef GUMNUT_INT_SYNC_EN
    logic [7:0] sync1, sync2;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1    <= 8'h00;
            sync2    <= 8'h00;
            src_prev <= 8'h00;
        end else begin
            sync1    <= irq_i;
            sync2    <= sync1;
            src_prev <= sync2;
        end
    end

    assign src = sync2;
`else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_prev <= 8'h00;
        end else begin
            src_prev <= irq_i;
        end
    end

    assign src = irq_i;
`endif

    assign rise   = src & ~src_prev;
    assign clr    = wr_status ? port_dat_i : 8'h00;
    assign masked = pending & mask;

    // Edge bits: clear first, then OR in the new rise so a simultaneous
    // set beats the write-1-to-clear. Level bits simply track the source.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending <= 8'h00;
            mask    <= 8'h00;
            mode    <= 8'h00;
        end else begin
            pending <= (mode & ((pending & ~clr) | rise)) | (~mode & src);
            if (wr_mask) mask <= port_dat_i;
            if (wr_mode) mode <= port_dat_i;
        end
    end

    // Lowest-numbered enabled pending source has priority.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        case (state)
            IDLE: begin
                if (masked != 8'h00) state_next = REQ;
            end
            REQ: begin
                // Withdrawn request wins over a same-cycle ack: nothing left to report.
                if (masked == 8'h00) begin
                    state_next = IDLE;
                end else if (int_ack_i) begin
                    cause_next = {1'b1, 4'b0000, low_idx};
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_cause) begin
                    cause_next = {1'b0, cause[6:0]};
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cause     <= 8'h00;
            int_req_o <= 1'b0;
        end else begin
            state     <= state_next;
            cause     <= cause_next;
            int_req_o <= (state_next == REQ);
        end
    end

    always_comb begin
        port_dat_o = 8'h00;
        if (hit) begin
            case (offset[1:0])
                2'd0:    port_dat_o = pending;
                2'd1:    port_dat_o = mask;
                2'd2:    port_dat_o = cause;
                default: port_dat_o = mode;
            endcase
        end
    end

endmodule

// File: tb/tb_gumnut_int_ctrl.sv
// tb/tb_gumnut_int_ctrl.sv - self-checking bench for gumnut_int_ctrl

module tb_gumnut_int_ctrl;

    localparam logic [7:0] BASE = 8'hF0;
`ifdef GUMNUT_INT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] irq_i;
    logic [7:0] port_adr_i;
    logic [7:0] port_dat_i;
    logic       port_we_i;
    logic [7:0] port_dat_o;
    logic       int_req_o;
    logic       int_ack_i;

    gumnut_int_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .irq_i      (irq_i),
        .port_adr_i (port_adr_i),
        .port_dat_i (port_dat_i),
        .port_we_i  (port_we_i),
        .port_dat_o (port_dat_o),
        .int_req_o  (int_req_o),
        .int_ack_i  (int_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: irq history as a delay line, pending/mask/mode/cause
    // as plain bytes, controller status as two flags.
    logic [7:0] dl [0:3];
    logic [7:0] m_pend, m_mask, m_mode, m_cause;
    bit         m_req, m_svc;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) dl[i] = 8'h00;
        m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'h00; m_cause = 8'h00;
        m_req = 0; m_svc = 0;
    endtask

    task automatic model_edge(input logic [7:0] irq, input logic [7:0] adr,
                              input logic [7:0] dat, input logic we, input logic ack);
        logic [7:0] masked, src, prev, clr;
        int a, off;
        bit hit;
        for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = irq;
        src  = dl[D];
        prev = dl[D+1];
        a    = int'(adr);
        hit  = (a >= int'(BASE)) && (a <= int'(BASE) + 3);
        off  = a - int'(BASE);
        masked = m_pend & m_mask;
        if (m_req) begin
            if (masked == 8'h00) m_req = 0;
            else if (ack) begin
                for (int b = 7; b >= 0; b--) if (masked[b]) m_cause = 8'h80 + 8'(b);
                m_req = 0;
                m_svc = 1;
            end
        end else if (m_svc) begin
            if (we && hit && off == 2) begin
                m_cause[7] = 1'b0;
                m_svc = 0;
            end
        end else if (masked != 8'h00) begin
            m_req = 1;
        end
        clr = (we && hit && off == 0) ? dat : 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (m_mode[b]) m_pend[b] = (m_pend[b] & ~clr[b]) | (src[b] & ~prev[b]);
            else           m_pend[b] = src[b];
        end
        if (we && hit && off == 1) m_mask = dat;
        if (we && hit && off == 3) m_mode = dat;
    endtask

    task automatic check_all();
        logic [7:0] exp [0:3];
        exp[0] = m_pend; exp[1] = m_mask; exp[2] = m_cause; exp[3] = m_mode;
        chk("int_req", {7'b0, int_req_o}, {7'b0, m_req});
        for (int a = 0; a < 4; a++) begin
            port_adr_i = BASE + 8'(a);
            #1;
            chk($sformatf("reg%0d", a), port_dat_o, exp[a]);
        end
        port_adr_i = BASE + 8'd4;
        #1;
        chk("miss_hi", port_dat_o, 8'h00);
        port_adr_i = BASE - 8'd1;
        #1;
        chk("miss_lo", port_dat_o, 8'h00);
    endtask

    task automatic cycle(input logic [7:0] irq, input logic [7:0] adr,
                         input logic [7:0] dat, input logic we, input logic ack);
        irq_i = irq; port_adr_i = adr; port_dat_i = dat; port_we_i = we; int_ack_i = ack;
        model_edge(irq, adr, dat, we, ack);
        @(posedge clk_i);
        #1;
        port_we_i = 1'b0;
        int_ack_i = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] dat);
        cycle(irq_i, BASE + off, dat, 1'b1, 1'b0);
    endtask

    task automatic idle(input logic [7:0] irq);
        cycle(irq, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] v);
        port_adr_i = BASE + off;
        #1;
        v = port_dat_o;
    endtask

    task automatic wait_req(input logic [7:0] irq);
        for (int n = 0; n < 10 && int_req_o !== 1'b1; n++) idle(irq);
        chk("wait_req", {7'b0, int_req_o}, 8'h01);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk("rst_req_async", {7'b0, int_req_o}, 8'h00);
        model_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        logic [7:0] v, irq_r;
        int n;

        rst_i = 1'b0; irq_i = 8'h00; port_adr_i = 8'h00; port_dat_i = 8'h00;
        port_we_i = 1'b0; int_ack_i = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Edge source 2: latency to pending, request, ack -> CAUSE 82.
        wr(8'd1, 8'h04);
        wr(8'd3, 8'h04);
        n = 0;
        do begin
            idle((n == 0) ? 8'h04 : 8'h00);
            n++;
            rd(8'd0, v);
        end while (v[2] !== 1'b1 && n < 8);
        chk("edge_latency", 8'(n), 8'(D + 1));
        chk("status_edge", v, 8'h04);
        idle(8'h00);
        chk("req_after_pend", {7'b0, int_req_o}, 8'h01);
        cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("req_drop_ack", {7'b0, int_req_o}, 8'h00);
        rd(8'd2, v);
        chk("cause_82", v, 8'h82);
        wr(8'd0, 8'h04);
        wr(8'd2, 8'h00);

        // Two simultaneous edges: lowest index first, then the other.
        wr(8'd1, 8'hFF);
        wr(8'd3, 8'hFF);
        idle(8'h22);
        wait_req(8'h22);
        cycle(8'h22, 8'h00, 8'h00, 1'b0, 1'b1);
        rd(8'd2, v);
        chk("cause_81", v, 8'h81);
        wr(8'd0, 8'h02);
        wr(8'd2, 8'h00);
        chk("idle_after_eoi", {7'b0, int_req_o}, 8'h00);
        idle(8'h22);
        chk("rereq", {7'b0, int_req_o}, 8'h01);
        cycle(8'h22, 8'h00, 8'h00, 1'b0, 1'b1);
        rd(8'd2, v);
        chk("cause_85", v, 8'h85);
        wr(8'd2, 8'h00);
        wr(8'd0, 8'h20);
        idle(8'h00);

        // Level source 0 withdrawn before ack.
        do_reset();
        wr(8'd1, 8'h01);
        idle(8'h01);
        wait_req(8'h01);
        rd(8'd0, v);
        chk("level_status_1", v, 8'h01);
        for (n = 0; n < 10 && int_req_o !== 1'b0; n++) idle(8'h00);
        chk("level_req_drop", {7'b0, int_req_o}, 8'h00);
        rd(8'd0, v);
        chk("level_status_0", v, 8'h00);
        rd(8'd2, v);
        chk("cause_unchanged", v, 8'h00);
        wr(8'd0, 8'hFF);

        // Set beats clear on the same edge bit.
        do_reset();
        wr(8'd3, 8'h08);
        idle(8'h08);
        for (int i = 0; i < 2 * (D + 1); i++) idle(8'h00);
        rd(8'd0, v);
        chk("pend3_set", v, 8'h08);
        for (int i = 0; i < D; i++) idle(8'h08);
        cycle(8'h08, BASE, 8'h08, 1'b1, 1'b0);
        rd(8'd0, v);
        chk("set_wins", v, 8'h08);
        wr(8'd0, 8'h08);
        rd(8'd0, v);
        chk("w1c_clears", v, 8'h00);

        // Reset while requesting; out-of-range writes.
        wr(8'd1, 8'h04);
        wr(8'd3, 8'h04);
        idle(8'h04);
        idle(8'h00);
        wait_req(8'h00);
        do_reset();
        cycle(8'h00, BASE + 8'd4, 8'hFF, 1'b1, 1'b0);
        cycle(8'h00, BASE - 8'd1, 8'hFF, 1'b1, 1'b0);
        rd(8'd1, v);
        chk("oob_mask", v, 8'h00);

        // Randomized traffic against the model.
        irq_r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            irq_r = irq_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cycle(irq_r, BASE - 8'd1 + 8'($urandom_range(0, 5)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gumnut_int_ctrl.md
GUMNUT_INT_CTRL -- requirements
Module: gumnut_int_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'hF0, meaning the port address of register 0; registers occupy BASE_ADDR+0..+3.
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port irq_i  input  8  external interrupt sources, asynchronous to clk_i.
REQ-005 The block SHALL have port port_adr_i  input  8  port address from core.
REQ-006 The block SHALL have port port_dat_i  input  8  port write data from core.
REQ-007 The block SHALL have port port_we_i  input  1  port write strobe, one cycle per write.
REQ-008 The block SHALL have port port_dat_o  output  8  read data for the addressed register, 8'h00 when the address misses, so it is OR-able onto the core input bus.
REQ-009 The block SHALL have port int_req_o  output  1  interrupt request to core.
REQ-010 The block SHALL have port int_ack_i  input  1  interrupt acknowledge from core.

Function
REQ-011 Register map SHALL be: +0 STATUS (pending[7:0], read; write-1-to-clear); +1 MASK (R/W, 1 = enabled); +2 CAUSE (read: {valid, 4'b0, idx[2:0]}; any write = end-of-interrupt); +3 MODE (R/W, 1 = edge, 0 = level per bit).
REQ-012 port_dat_o SHALL be combinational from port_adr_i and register state, with zero read latency; writes SHALL take effect on the clock edge where port_we_i=1.
REQ-013 An edge-mode pending bit SHALL set on a detected 0->1 transition of its sampled source and clear only via STATUS write-1.
REQ-014 A level-mode pending bit SHALL equal the sampled source every cycle; STATUS writes SHALL have no effect on it.
REQ-015 When set and clear hit the same edge-mode bit in the same cycle, set SHALL win.
REQ-016 MASK SHALL NOT gate pending capture; it gates only request generation.
REQ-017 The FSM SHALL have states IDLE, REQ, SERVICE.
REQ-018 IDLE->REQ SHALL occur on the edge where (pending & MASK) != 0; int_req_o is registered and SHALL be 1 exactly in REQ.
REQ-019 In REQ with int_ack_i=1, the FSM SHALL latch CAUSE = {1, lowest-index set bit of pending&MASK} and move to SERVICE; int_req_o SHALL be 0 the following cycle.
REQ-020 If pending&MASK becomes 0 while in REQ without ack, the FSM SHALL return to IDLE, drop int_req_o, and leave CAUSE unchanged.
REQ-021 In SERVICE, a write to CAUSE SHALL clear CAUSE.valid and move to IDLE; a new request SHALL assert no earlier than the next edge.
REQ-022 int_ack_i outside REQ SHALL be ignored, and a CAUSE write outside SERVICE SHALL be ignored.
REQ-023 Writes to addresses outside BASE_ADDR..BASE_ADDR+3 SHALL change no state; BASE_ADDR+3 SHALL NOT wrap past 8'hFF (BASE_ADDR SHALL be <= 8'hFC).

Reset
REQ-024 rst_i=0 SHALL immediately force: state IDLE, int_req_o 0, pending 8'h00, MASK 8'h00, MODE 8'h00, CAUSE 8'h00, all sampling/synchronizer flops 0; port_dat_o thereby reads 8'h00.
REQ-025 Reset asserted mid-REQ or mid-SERVICE SHALL drop int_req_o without waiting for a clock edge; a pending edge event SHALL be lost.

Configuration
REQ-026 Macro GUMNUT_INT_SYNC_EN, when defined, SHALL insert a two-flop synchronizer per irq_i bit before edge/level sampling; an irq_i rise SHALL set pending on the 3rd rising edge.
REQ-027 Without GUMNUT_INT_SYNC_EN, irq_i SHALL be used directly with one history flop for edge detection; pending SHALL set on the 1st rising edge; all other behaviour SHALL be identical.

Verification
REQ-028 MASK=8'h04, MODE=8'h04, pulse irq_i[2] -> STATUS=8'h04, int_req_o=1 one edge after pending sets; ack -> CAUSE=8'h82, int_req_o=0 next cycle.
REQ-029 MASK=8'hFF, MODE=8'hFF, raise irq_i[5] and irq_i[1] together, ack -> CAUSE=8'h81; write STATUS=8'h02, write CAUSE -> IDLE then REQ again, ack -> CAUSE=8'h85.
REQ-030 MODE=8'h00, MASK=8'h01, hold irq_i[0]=1 then drop before ack -> STATUS follows input (8'h01 -> 8'h00), int_req_o returns to 0, CAUSE stays 8'h00.
REQ-031 Edge bit 3 pending; same cycle STATUS write 8'h08 and new irq_i[3] edge -> STATUS remains 8'h08.
REQ-032 rst_i=0 while in REQ -> int_req_o=0 before the next edge; all registers read 8'h00; write to BASE_ADDR+4 -> no register changes.
REQ-033 Run REQ-028 with and without GUMNUT_INT_SYNC_EN -> pending sets on the 3rd vs the 1st edge after the irq_i rise.
